// File: rtl/flag_update_sequencer_if.sv
// Operation request channel into the flag update sequencer.
interface flag_update_sequencer_if #(
  parameter int NFLAGS = 6
);
  logic              OpValid;
  logic              OpReady;
  logic [1:0]        OpKind;
  logic [1:0]        OpWidth;
  logic [NFLAGS-1:0] OpFlagMask;

  modport master (
    output OpValid, OpKind, OpWidth, OpFlagMask,
    input  OpReady
  );

  modport slave (
    input  OpValid, OpKind, OpWidth, OpFlagMask,
    output OpReady
  );
endinterface

// File: rtl/flag_update_sequencer.sv
// Steps the byte-serial ALU through 1-3 slices and drives the flag register
// write strobes, S source selects, shadow exchange and load-F strobes.
//
// state | meaning
// IDLE  | no operation in progress, ready for a request
// SLICE | ALU slice cycle; cnt == last is the commit cycle
// EX    | one-cycle shadow flag exchange strobe
// LOAD  | one-cycle load of F from the result bus
module flag_update_sequencer #(
  parameter int NFLAGS = 6
) (
  input  logic              Clk,
  input  logic              Reset,
  flag_update_sequencer_if.slave op,
  output logic [1:0]        SliceIndex,
  output logic              SliceFirst,
  output logic              SliceActive,
  output logic [NFLAGS-1:0] PF_Write,
  output logic              notPF_Select_S_bit7,
  output logic              notPF_Select_S_bit15,
  output logic              notPF_Select_S_bit23,
  output logic              PR_Ex,
  output logic              notPR_Ex,
  output logic              PR_Write,
  output logic              notPR_Write,
  output logic              ErrIllegal
);
  localparam int FLAG_S = NFLAGS - 1;

  typedef enum logic [1:0] {IDLE, SLICE, EX, LOAD} state_t;

  state_t            state, state_nx;
  logic [1:0]        cnt, cnt_nx;
  logic [1:0]        last, last_nx;
  logic [NFLAGS-1:0] mask, mask_nx;
  logic              ready_q;
  logic              accept;
  logic              err_nx;
  logic              commit_nx;

  assign op.OpReady  = ready_q;
  assign notPR_Ex    = ~PR_Ex;
  assign notPR_Write = ~PR_Write;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    last_nx  = last;
    mask_nx  = mask;
    err_nx   = ErrIllegal;
    accept   = op.OpValid & ready_q;
    case (state)
      SLICE: begin
        if (cnt != last) begin
          cnt_nx = cnt + 2'd1;
        end else begin
          state_nx = IDLE;
          cnt_nx   = 2'd0;
        end
      end
      EX, LOAD: state_nx = IDLE;
      default: ;
    endcase
    // A request accepted on the final cycle of an op overrides the return to IDLE.
    if (accept) begin
      case (op.OpKind)
        2'd0: begin
          state_nx = SLICE;
          cnt_nx   = 2'd0;
          last_nx  = (op.OpWidth == 2'd3) ? 2'd0 : op.OpWidth;
          mask_nx  = op.OpFlagMask;
          if (op.OpWidth == 2'd3) err_nx = 1'b1;
        end
        2'd1:    state_nx = EX;
        2'd2:    state_nx = LOAD;
        default: err_nx = 1'b1;
      endcase
    end
    commit_nx = (state_nx == SLICE) && (cnt_nx == last_nx);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state                <= IDLE;
      cnt                  <= 2'd0;
      last                 <= 2'd0;
      mask                 <= '0;
      ready_q              <= 1'b1;
      SliceActive          <= 1'b0;
      SliceIndex           <= 2'd0;
      SliceFirst           <= 1'b0;
      PF_Write             <= '0;
      notPF_Select_S_bit7  <= 1'b1;
      notPF_Select_S_bit15 <= 1'b1;
      notPF_Select_S_bit23 <= 1'b1;
      PR_Ex                <= 1'b0;
      PR_Write             <= 1'b0;
      ErrIllegal           <= 1'b0;
    end else begin
      state                <= state_nx;
      cnt                  <= cnt_nx;
      last                 <= last_nx;
      mask                 <= mask_nx;
      ready_q              <= (state_nx != SLICE) || commit_nx;
      SliceActive          <= (state_nx == SLICE);
      SliceIndex           <= (state_nx == SLICE) ? cnt_nx : 2'd0;
      SliceFirst           <= (state_nx == SLICE) && (cnt_nx == 2'd0);
      PF_Write             <= commit_nx ? mask_nx : '0;
      notPF_Select_S_bit7  <= ~(commit_nx && mask_nx[FLAG_S] && (last_nx == 2'd0));
      notPF_Select_S_bit15 <= ~(commit_nx && mask_nx[FLAG_S] && (last_nx == 2'd1));
      notPF_Select_S_bit23 <= ~(commit_nx && mask_nx[FLAG_S] && (last_nx == 2'd2));
      PR_Ex                <= (state_nx == EX);
      PR_Write             <= (state_nx == LOAD);
      ErrIllegal           <= err_nx;
    end
  end
endmodule

// File: tb/tb_flag_update_sequencer.sv
// Scoreboard bench: each accepted op expands into its expected per-cycle
// output records; a negedge monitor pops and compares them.
module tb_flag_update_sequencer;
  localparam int NFLAGS = 6;

  typedef logic [16:0] out_t;

  logic              Clk;
  logic              Reset;
  logic [1:0]        SliceIndex;
  logic              SliceFirst;
  logic              SliceActive;
  logic [NFLAGS-1:0] PF_Write;
  logic              notPF_Select_S_bit7;
  logic              notPF_Select_S_bit15;
  logic              notPF_Select_S_bit23;
  logic              PR_Ex;
  logic              notPR_Ex;
  logic              PR_Write;
  logic              notPR_Write;
  logic              ErrIllegal;

  flag_update_sequencer_if #(.NFLAGS(NFLAGS)) op_if ();

  flag_update_sequencer #(.NFLAGS(NFLAGS)) dut (
    .Clk                  (Clk),
    .Reset                (Reset),
    .op                   (op_if.slave),
    .SliceIndex           (SliceIndex),
    .SliceFirst           (SliceFirst),
    .SliceActive          (SliceActive),
    .PF_Write             (PF_Write),
    .notPF_Select_S_bit7  (notPF_Select_S_bit7),
    .notPF_Select_S_bit15 (notPF_Select_S_bit15),
    .notPF_Select_S_bit23 (notPF_Select_S_bit23),
    .PR_Ex                (PR_Ex),
    .notPR_Ex             (notPR_Ex),
    .PR_Write             (PR_Write),
    .notPR_Write          (notPR_Write),
    .ErrIllegal           (ErrIllegal)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  out_t sb[$];
  logic err_exp = 1'b0;
  logic mon_en  = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  function automatic out_t mk(logic sact, logic [1:0] sidx, logic sfirst,
                              logic [NFLAGS-1:0] pfw, logic s7, logic s15,
                              logic s23, logic prex, logic prw);
    return {sact, sidx, sfirst, pfw, s7, s15, s23, prex, ~prex, prw, ~prw};
  endfunction

  // Idle: nothing strobed, S selects inactive (high).
  function automatic out_t idle_out();
    return mk(1'b0, 2'd0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endfunction

  task automatic push_op(input logic [1:0] kind, input logic [1:0] width,
                         input logic [NFLAGS-1:0] m);
    int w;
    logic s_on;
    case (kind)
      2'd0: begin
        w = (width == 2'd3) ? 0 : int'(width);
        if (width == 2'd3) err_exp = 1'b1;
        for (int i = 0; i <= w; i++) begin
          s_on = (i == w) && m[NFLAGS-1];
          sb.push_back(mk(1'b1, 2'(i), i == 0, (i == w) ? m : '0,
                          !(s_on && w == 0), !(s_on && w == 1), !(s_on && w == 2),
                          1'b0, 1'b0));
        end
      end
      2'd1: sb.push_back(mk(1'b0, 2'd0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
      2'd2: sb.push_back(mk(1'b0, 2'd0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
      default: err_exp = 1'b1;
    endcase
  endtask

  // One clock of stimulus; entered and left 1 time unit after a rising edge.
  task automatic drive_cycle(input logic v, input logic [1:0] kind,
                             input logic [1:0] width, input logic [NFLAGS-1:0] m,
                             output logic acc);
    op_if.OpValid    = v;
    op_if.OpKind     = kind;
    op_if.OpWidth    = width;
    op_if.OpFlagMask = m;
    @(negedge Clk);
    acc = v && op_if.OpReady && !Reset;
    @(posedge Clk);
    if (Reset) begin
      sb.delete();
      err_exp = 1'b0;
    end else if (acc) begin
      push_op(kind, width, m);
    end
    #1;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 2'd0, 2'd0, '0, acc);
  endtask

  task automatic issue(input logic [1:0] kind, input logic [1:0] width,
                       input logic [NFLAGS-1:0] m);
    logic acc;
    acc = 1'b0;
    for (int n = 0; n < 10 && !acc; n++) drive_cycle(1'b1, kind, width, m, acc);
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL issue_timeout t=%0t kind=%0d: request not accepted within 10 cycles, required acceptance", $time, kind);
    end
  endtask

  task automatic do_reset();
    logic acc;
    Reset = 1'b1;
    drive_cycle(1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom), 6'($urandom), acc);
    Reset = 1'b0;
  endtask

  initial begin : monitor
    out_t exp;
    out_t got;
    logic rdy_exp;
    forever begin
      @(negedge Clk);
      if (mon_en) begin
        exp = (sb.size() > 0) ? sb.pop_front() : idle_out();
        got = {SliceActive, SliceIndex, SliceFirst, PF_Write, notPF_Select_S_bit7,
               notPF_Select_S_bit15, notPF_Select_S_bit23, PR_Ex, notPR_Ex,
               PR_Write, notPR_Write};
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL outputs t=%0t got=%b required=%b (act,idx,first,pfw,s7,s15,s23,ex,nex,wr,nwr)",
                   $time, got, exp);
        end
        rdy_exp = (sb.size() == 0);
        checks++;
        if (op_if.OpReady !== rdy_exp) begin
          failures++;
          $display("FAIL op_ready t=%0t got=%b required=%b", $time, op_if.OpReady, rdy_exp);
        end
        checks++;
        if (ErrIllegal !== err_exp) begin
          failures++;
          $display("FAIL err_illegal t=%0t got=%b required=%b", $time, ErrIllegal, err_exp);
        end
      end
    end
  end

  initial begin : stimulus
    int r;
    Reset            = 1'b1;
    op_if.OpValid    = 1'b0;
    op_if.OpKind     = 2'd0;
    op_if.OpWidth    = 2'd0;
    op_if.OpFlagMask = '0;
    repeat (3) @(posedge Clk);
    #1;
    Reset  = 1'b0;
    mon_en = 1'b1;

    issue(2'd0, 2'd0, 6'b100001); idle(2);
    issue(2'd0, 2'd2, 6'b111111); idle(4);
    issue(2'd0, 2'd1, 6'b111111); issue(2'd1, 2'd0, '0); idle(2);
    issue(2'd0, 2'd1, 6'b011110); idle(3);
    issue(2'd0, 2'd0, 6'b000000); idle(2);
    issue(2'd2, 2'd0, '0); issue(2'd1, 2'd0, '0); issue(2'd2, 2'd0, '0); idle(2);
    issue(2'd0, 2'd3, 6'b100001); idle(2);
    issue(2'd3, 2'd0, '0); idle(3);
    issue(2'd0, 2'd2, 6'b111111); idle(1);
    do_reset(); idle(3);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 39);
      if (r == 0) do_reset();
      else if (r < 8) idle(1);
      else issue(2'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0) ? '0 : 6'($urandom));
    end
    idle(5);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending records required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
